slave_port: RTL and testbench
=============================

SLAVE_PORT -- requirements
Module: slave_port

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 12, address bits received per transaction; DATA_WIDTH, default 8, data bits per transfer.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset; sampled only on rising clk edge.
REQ-004 valid  input  1  master transaction-valid from bus mux.
REQ-005 rx_address  input  1  serial address bit, LSB first.
REQ-006 rx_data  input  1  serial write-data bit, LSB first.
REQ-007 write_en  input  1  write request; sampled at transaction start only.
REQ-008 read_en  input  1  read request; sampled at transaction start only.
REQ-009 tx_data  output  1  serial read-data bit to master, LSB first.
REQ-010 tx_valid  output  1  high while tx_data carries a read bit.
REQ-011 slave_ready  output  1  high only when idle and able to accept a transaction.
REQ-012 mem_addr  output  ADDR_WIDTH  assembled address to local memory.
REQ-013 mem_wdata  output  DATA_WIDTH  assembled write data.
REQ-014 mem_wen  output  1  one-cycle memory write strobe.
REQ-015 mem_ren  output  1  one-cycle memory read strobe.
REQ-016 mem_rdata  input  DATA_WIDTH  memory read data, valid exactly one cycle after mem_ren.

Function
REQ-017 FSM states SHALL be IDLE, ADDR, WDATA, MEM_WR, MEM_RD, RWAIT, RDATA; one bit counter sized for max(ADDR_WIDTH, DATA_WIDTH).
REQ-018 IDLE: slave_ready=1; start = valid=1 with exactly one of write_en/read_en high; on start, latch op, capture rx_address into mem_addr[0], go to ADDR with count=1.
REQ-019 IDLE with valid=1 and write_en=read_en (both or neither) SHALL be ignored: stay IDLE, no register change.
REQ-020 ADDR: each cycle capture rx_address into mem_addr[count]; after bit ADDR_WIDTH-1 go to WDATA (write) or MEM_RD (read), count=0.
REQ-021 WDATA: each cycle capture rx_data into mem_wdata[count]; after bit DATA_WIDTH-1 go to MEM_WR.
REQ-022 MEM_WR: mem_wen=1 for exactly one cycle with stable mem_addr/mem_wdata; next state IDLE.
REQ-023 MEM_RD: mem_ren=1 one cycle; RWAIT: latch mem_rdata into read shift register; next RDATA.
REQ-024 RDATA: tx_valid=1, tx_data=rdata bit count (LSB first) for DATA_WIDTH cycles; then IDLE.
REQ-025 Write latency: start at cycle 0 -> mem_wen at cycle ADDR_WIDTH+DATA_WIDTH; slave_ready high again cycle ADDR_WIDTH+DATA_WIDTH+1.
REQ-026 Read latency: mem_ren at cycle ADDR_WIDTH; tx_valid cycles ADDR_WIDTH+2 .. ADDR_WIDTH+DATA_WIDTH+1; IDLE at ADDR_WIDTH+DATA_WIDTH+2.
REQ-027 valid dropping to 0 during ADDR or WDATA SHALL abort: next state IDLE, no mem_wen/mem_ren pulse; valid is ignored from MEM_RD onward.
REQ-028 write_en/read_en changes after the start cycle SHALL be ignored.
REQ-029 slave_ready, mem_wen, mem_ren, tx_valid SHALL be registered or decoded from state only (no combinational path from inputs).
REQ-030 tx_data SHALL be 0 whenever tx_valid=0.

Reset
REQ-031 rst=0 at a rising edge SHALL force IDLE, count=0, mem_addr=0, mem_wdata=0, read register=0, slave_ready=1, tx_valid=0, tx_data=0, mem_wen=0, mem_ren=0.
REQ-032 Reset mid-transaction (any state) SHALL abort with no memory strobe on the following cycle; rst low while valid high SHALL not start a transaction.

Verification
REQ-033 Write: serial addr 0xA53, data 0x3C, write_en=1 -> mem_wen single pulse at cycle 20, mem_addr=0xA53, mem_wdata=0x3C, slave_ready=1 at cycle 21.
REQ-034 Read: addr 0x00F, read_en=1, mem_rdata=0x81 at cycle 13 -> mem_ren at cycle 12; tx_data 1,0,0,0,0,0,0,1 with tx_valid on cycles 14-21.
REQ-035 Abort: valid low at address bit 5 -> IDLE next cycle, no mem_wen/mem_ren, slave_ready=1.
REQ-036 Illegal start: valid=1, write_en=read_en=1 for 3 cycles -> remains IDLE, slave_ready=1, no strobes.
REQ-037 Reset in WDATA bit 3 -> all outputs at reset values next cycle; subsequent legal write completes correctly.
REQ-038 Back-to-back: read immediately after write completes -> second start accepted in first cycle slave_ready=1, both transfers correct.

Source files
------------

// File: rtl/slave_port_if.sv
// Serial bus between a bus-mux master and a slave_port: transaction control,
// serial address/data toward the slave and serial read data back.
interface slave_port_if;
  logic valid;
  logic rx_address;
  logic rx_data;
  logic write_en;
  logic read_en;
  logic tx_data;
  logic tx_valid;
  logic slave_ready;

  modport master (
    output valid,
    output rx_address,
    output rx_data,
    output write_en,
    output read_en,
    input  tx_data,
    input  tx_valid,
    input  slave_ready
  );

  modport slave (
    input  valid,
    input  rx_address,
    input  rx_data,
    input  write_en,
    input  read_en,
    output tx_data,
    output tx_valid,
    output slave_ready
  );
endinterface

// File: rtl/slave_port.sv
// Serial-to-parallel slave port: collects an LSB-first address (and write data),
// strobes the local memory once, and returns read data serially LSB first.
module slave_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  slave_port_if.slave           bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    WDATA  = 3'd2,
    MEM_WR = 3'd3,
    MEM_RD = 3'd4,
    RWAIT  = 3'd5,
    RDATA  = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    op_wr_q, op_wr_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    slave_ready_q, slave_ready_d;
  logic                    mem_wen_q, mem_wen_d;
  logic                    mem_ren_q, mem_ren_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    tx_data_q, tx_data_d;
  logic [DATA_WIDTH-1:0]   rdata_shift_s;
  logic                    start_s;

  // Next-state, datapath capture and next-cycle output decode
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    op_wr_d       = op_wr_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rdata_d       = rdata_q;
    rdata_shift_s = '0;
    start_s       = bus.valid & (bus.write_en ^ bus.read_en);

    case (state_q)
      IDLE: begin
        if (start_s) begin
          op_wr_d       = bus.write_en;
          mem_addr_d[0] = bus.rx_address;
          count_d       = CNT_W'(1);
          state_d       = ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        if (!bus.valid) begin
          count_d = '0;
          state_d = IDLE;
        end else begin
          for (int i = 0; i < ADDR_WIDTH; i++) begin
            if (count_q == CNT_W'(i)) begin
              mem_addr_d[i] = bus.rx_address;
            end else begin
              mem_addr_d[i] = mem_addr_q[i];
            end
          end
          if (count_q == ADDR_LAST) begin
            count_d = '0;
            state_d = op_wr_q ? WDATA : MEM_RD;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      WDATA: begin
        if (!bus.valid) begin
          count_d = '0;
          state_d = IDLE;
        end else begin
          for (int i = 0; i < DATA_WIDTH; i++) begin
            if (count_q == CNT_W'(i)) begin
              mem_wdata_d[i] = bus.rx_data;
            end else begin
              mem_wdata_d[i] = mem_wdata_q[i];
            end
          end
          if (count_q == DATA_LAST) begin
            count_d = '0;
            state_d = MEM_WR;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      MEM_WR: begin
        state_d = IDLE;
      end
      MEM_RD: begin
        state_d = RWAIT;
      end
      RWAIT: begin
        // Memory answers exactly one cycle after the read strobe
        rdata_d = mem_rdata;
        count_d = '0;
        state_d = RDATA;
      end
      RDATA: begin
        if (count_q == DATA_LAST) begin
          count_d = '0;
          state_d = IDLE;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase

    // Handshake outputs depend only on the state being entered, never on inputs
    slave_ready_d = (state_d == IDLE);
    mem_wen_d     = (state_d == MEM_WR);
    mem_ren_d     = (state_d == MEM_RD);
    tx_valid_d    = (state_d == RDATA);
    rdata_shift_s = rdata_d >> count_d;
    tx_data_d     = tx_valid_d & rdata_shift_s[0];
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      count_q       <= '0;
      op_wr_q       <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rdata_q       <= '0;
      slave_ready_q <= 1'b1;
      mem_wen_q     <= 1'b0;
      mem_ren_q     <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      op_wr_q       <= op_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rdata_q       <= rdata_d;
      slave_ready_q <= slave_ready_d;
      mem_wen_q     <= mem_wen_d;
      mem_ren_q     <= mem_ren_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
    end
  end

  assign bus.slave_ready = slave_ready_q;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.tx_data     = tx_data_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_wen         = mem_wen_q;
  assign mem_ren         = mem_ren_q;

endmodule

// File: tb/tb_slave_port.sv
// Scoreboard bench for slave_port: write/read transfers, latency, abort,
// illegal start, reset in flight and back-to-back traffic.
module tb_slave_port;
  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_wen;
  logic          mem_ren;

  always #5 clk = ~clk;

  slave_port_if bus();

  slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen),
    .mem_ren   (mem_ren),
    .mem_rdata (mem_rdata)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t  wr_q[$];
  logic tx_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   wen_cnt = 0;
  int   ren_cnt = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
    if (mem_wen) wen_cnt++;
    if (mem_ren) ren_cnt++;
  endtask

  task automatic idle_inputs();
    bus.valid      = 1'b0;
    bus.write_en   = 1'b0;
    bus.read_en    = 1'b0;
    bus.rx_address = 1'b0;
    bus.rx_data    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.valid = 1'b1; bus.write_en = 1'b1; bus.read_en = 1'b0; bus.rx_address = 1'b1;
    repeat (3) cyc();
    n_tests++; if (bus.slave_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", bus.slave_ready); end
    n_tests++; if ({bus.tx_valid, bus.tx_data, mem_wen, mem_ren} !== 4'b0000) begin n_fail++; $display("FAIL rst_strobes got %b want 0000", {bus.tx_valid, bus.tx_data, mem_wen, mem_ren}); end
    n_tests++; if (mem_addr !== 12'h000 || mem_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_regs got %h/%h want 000/00", mem_addr, mem_wdata); end
    rst = 1'b1;
    idle_inputs();
    cyc();
    n_tests++; if (bus.slave_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got %b want 1", bus.slave_ready); end
  endtask

  task automatic test_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    n_tests++; if (bus.slave_ready !== 1'b1) begin n_fail++; $display("FAIL wr_start_ready got %b want 1", bus.slave_ready); end
    wr_q.push_back('{a: a, d: d});
    wen_cnt = 0; ren_cnt = 0;
    bus.valid = 1'b1; bus.write_en = 1'b1; bus.read_en = 1'b0;
    bus.rx_address = a[0]; bus.rx_data = 1'($urandom);
    for (int k = 1; k < AW; k++) begin
      cyc();
      bus.rx_address = a[k];
      bus.write_en = 1'($urandom); bus.read_en = 1'($urandom);
    end
    for (int k = 0; k < DW; k++) begin
      cyc();
      bus.rx_data = d[k]; bus.rx_address = 1'($urandom);
    end
    cyc();
    e = wr_q.pop_front();
    n_tests++; if (mem_wen !== 1'b1 || wen_cnt != 1) begin n_fail++; $display("FAIL wr_wen_timing got wen=%b cnt=%0d want 1/1", mem_wen, wen_cnt); end
    n_tests++; if (mem_addr !== e.a) begin n_fail++; $display("FAIL wr_addr got %h want %h", mem_addr, e.a); end
    n_tests++; if (mem_wdata !== e.d) begin n_fail++; $display("FAIL wr_data got %h want %h", mem_wdata, e.d); end
    n_tests++; if (bus.slave_ready !== 1'b0) begin n_fail++; $display("FAIL wr_busy_ready got %b want 0", bus.slave_ready); end
    idle_inputs();
    cyc();
    n_tests++; if (bus.slave_ready !== 1'b1 || mem_wen !== 1'b0) begin n_fail++; $display("FAIL wr_end got ready=%b wen=%b want 1/0", bus.slave_ready, mem_wen); end
    n_tests++; if (wen_cnt != 1 || ren_cnt != 0) begin n_fail++; $display("FAIL wr_pulses got wen=%0d ren=%0d want 1/0", wen_cnt, ren_cnt); end
  endtask

  task automatic test_read(input logic [AW-1:0] a, input logic [DW-1:0] r);
    logic eb;
    n_tests++; if (bus.slave_ready !== 1'b1) begin n_fail++; $display("FAIL rd_start_ready got %b want 1", bus.slave_ready); end
    for (int i = 0; i < DW; i++) tx_q.push_back(r[i]);
    wen_cnt = 0; ren_cnt = 0;
    mem_rdata = ~r;
    bus.valid = 1'b1; bus.write_en = 1'b0; bus.read_en = 1'b1; bus.rx_address = a[0];
    for (int k = 1; k < AW; k++) begin
      cyc();
      bus.rx_address = a[k];
      bus.write_en = 1'($urandom); bus.read_en = 1'($urandom);
    end
    cyc();
    n_tests++; if (mem_ren !== 1'b1 || ren_cnt != 1) begin n_fail++; $display("FAIL rd_ren_timing got ren=%b cnt=%0d want 1/1", mem_ren, ren_cnt); end
    n_tests++; if (mem_addr !== a) begin n_fail++; $display("FAIL rd_addr got %h want %h", mem_addr, a); end
    idle_inputs();
    cyc();
    mem_rdata = r;
    n_tests++; if ({bus.tx_valid, bus.tx_data, mem_ren} !== 3'b000) begin n_fail++; $display("FAIL rd_wait got %b want 000", {bus.tx_valid, bus.tx_data, mem_ren}); end
    cyc();
    mem_rdata = ~r;
    for (int i = 0; i < DW; i++) begin
      eb = tx_q.pop_front();
      n_tests++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== eb) begin n_fail++; $display("FAIL rd_bit%0d got v=%b d=%b want 1/%b", i, bus.tx_valid, bus.tx_data, eb); end
      cyc();
    end
    n_tests++; if ({bus.slave_ready, bus.tx_valid, bus.tx_data} !== 3'b100) begin n_fail++; $display("FAIL rd_end got %b want 100", {bus.slave_ready, bus.tx_valid, bus.tx_data}); end
    n_tests++; if (wen_cnt != 0 || ren_cnt != 1) begin n_fail++; $display("FAIL rd_pulses got wen=%0d ren=%0d want 0/1", wen_cnt, ren_cnt); end
  endtask

  task automatic test_illegal(input logic [AW-1:0] held_addr);
    wen_cnt = 0; ren_cnt = 0;
    bus.valid = 1'b1; bus.write_en = 1'b1; bus.read_en = 1'b1; bus.rx_address = ~held_addr[0];
    for (int k = 0; k < 5; k++) begin
      if (k == 3) begin bus.write_en = 1'b0; bus.read_en = 1'b0; end
      cyc();
      n_tests++; if (bus.slave_ready !== 1'b1) begin n_fail++; $display("FAIL ill_ready%0d got %b want 1", k, bus.slave_ready); end
    end
    n_tests++; if (mem_addr !== held_addr) begin n_fail++; $display("FAIL ill_addr got %h want %h", mem_addr, held_addr); end
    n_tests++; if (wen_cnt != 0 || ren_cnt != 0) begin n_fail++; $display("FAIL ill_pulses got wen=%0d ren=%0d want 0/0", wen_cnt, ren_cnt); end
    idle_inputs();
    cyc();
  endtask

  task automatic test_abort(input logic is_wr);
    wen_cnt = 0; ren_cnt = 0;
    bus.valid = 1'b1; bus.write_en = is_wr; bus.read_en = ~is_wr; bus.rx_address = 1'b1;
    for (int k = 1; k < 5; k++) begin
      cyc();
      bus.rx_address = 1'($urandom);
    end
    cyc();
    bus.valid = 1'b0;
    cyc();
    n_tests++; if (bus.slave_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready(wr=%b) got %b want 1", is_wr, bus.slave_ready); end
    idle_inputs();
    repeat (20) cyc();
    n_tests++; if (wen_cnt != 0 || ren_cnt != 0 || bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL abort_pulses(wr=%b) got wen=%0d ren=%0d txv=%b want 0/0/0", is_wr, wen_cnt, ren_cnt, bus.tx_valid); end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = 12'h123; d = 8'h5A;
    wen_cnt = 0; ren_cnt = 0;
    bus.valid = 1'b1; bus.write_en = 1'b1; bus.read_en = 1'b0; bus.rx_address = a[0];
    for (int k = 1; k < AW; k++) begin cyc(); bus.rx_address = a[k]; end
    for (int k = 0; k < 3; k++) begin cyc(); bus.rx_data = d[k]; end
    cyc();
    bus.rx_data = d[3];
    rst = 1'b0;
    cyc();
    n_tests++; if ({bus.slave_ready, bus.tx_valid, bus.tx_data, mem_wen, mem_ren} !== 5'b10000) begin n_fail++; $display("FAIL midrst_outs got %b want 10000", {bus.slave_ready, bus.tx_valid, bus.tx_data, mem_wen, mem_ren}); end
    n_tests++; if (mem_addr !== 12'h000 || mem_wdata !== 8'h00) begin n_fail++; $display("FAIL midrst_regs got %h/%h want 000/00", mem_addr, mem_wdata); end
    rst = 1'b1;
    idle_inputs();
    repeat (3) cyc();
    n_tests++; if (wen_cnt != 0 || ren_cnt != 0) begin n_fail++; $display("FAIL midrst_pulses got wen=%0d ren=%0d want 0/0", wen_cnt, ren_cnt); end
    test_write(12'h3C5, 8'hA7);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int n = 0; n < 3; n++) begin
      a = AW'($urandom); d = DW'($urandom);
      test_write(a, d);
      a = AW'($urandom); d = DW'($urandom);
      test_read(a, d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    mem_rdata = 8'h00;
    test_reset();
    test_write(12'hA53, 8'h3C);
    test_read(12'h00F, 8'h81);
    test_illegal(12'h00F);
    test_abort(1'b1);
    test_abort(1'b0);
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
